// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl -- WIDTH-bit adder built by time-multiplexing one 4-bit ripple
// adder (full_add_4) over NIB = WIDTH/4 cycles, least-significant nibble first.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request, accepted when start && ready at a rising edge
//   A, B   WIDTH-bit operands, sampled only at acceptance
//   Cin    carry-in, sampled only at acceptance
//   sub    subtract select (only when ADD_SEQ_SUB_EN is defined)
//   ready  can accept start (IDLE or DONE)
//   busy   operation in progress (RUN)
//   done   one-cycle pulse, Sum/Cout just updated
//   Sum    last completed result (registered)
//   Cout   carry out of the last completed result (registered)
//
// Optional feature macro: ADD_SEQ_SUB_EN (adds the sub port and A-B path).
// WIDTH must be a multiple of 4 and at least 8.

// 4-bit ripple-carry adder, combinational.
module full_add_4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);
    logic [4:0] w_c;

    always_comb begin
        Sum    = '0;
        w_c    = '0;
        w_c[0] = Cin;
        for (int i = 0; i < 4; i++) begin
            Sum[i]   = A[i] ^ B[i] ^ w_c[i];
            w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
        end
        Cout = w_c[4];
    end
endmodule

module add_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [IW-1:0]       r_idx;
    logic [NIB-1:0][3:0] r_opa;
    logic [NIB-1:0][3:0] r_opb;
    logic [NIB-1:0][3:0] r_acc;
    logic                r_cy;
    logic [WIDTH-1:0]    r_sum;
    logic                r_cout;

    logic [3:0]          w_nib_a;
    logic [3:0]          w_nib_b;
    logic [3:0]          w_nib_sum;
    logic                w_nib_cout;
    logic                w_last;
    logic [NIB-1:0][3:0] w_res;

    assign w_nib_a = r_opa[r_idx];
    assign w_nib_b = r_opb[r_idx];
    assign w_last  = (r_idx == IW'(NIB - 1));

    full_add_4 u_add (
        .A    (w_nib_a),
        .B    (w_nib_b),
        .Cin  (r_cy),
        .Sum  (w_nib_sum),
        .Cout (w_nib_cout)
    );

    // Final result: lower nibbles from the accumulator, top nibble straight
    // from the adder in the same cycle it is produced.
    always_comb begin
        w_res        = r_acc;
        w_res[NIB-1] = w_nib_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_cy    <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    // start is ignored here: no resample, no queueing
                    r_acc[r_idx] <= w_nib_sum;
                    r_cy         <= w_nib_cout;
                    r_idx        <= r_idx + IW'(1);
                    if (w_last) begin
                        r_sum   <= w_res;
                        r_cout  <= w_nib_cout;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE accept identically, giving back-to-back issue
                    if (start) begin
                        r_opa <= A;
                        r_idx <= '0;
`ifdef ADD_SEQ_SUB_EN
                        // A - B = A + ~B + 1; Cin is ignored when subtracting
                        r_opb <= sub ? ~B : B;
                        r_cy  <= sub | Cin;
`else
                        r_opb <= B;
                        r_cy  <= Cin;
`endif
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Status outputs decode the state register only.
    assign ready = (r_state != S_RUN);
    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign Sum   = r_sum;
    assign Cout  = r_cout;
endmodule

// File: tb/tb_add_seq_ctrl.sv
module tb_add_seq_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Cin = 1'b0;
    logic             sub_i = 1'b0;
    logic             ready, busy, done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    add_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
`ifdef ADD_SEQ_SUB_EN
        .sub   (sub_i),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An accepted request produces {Cout,Sum} = A+B+Cin (or A-B) exactly NIB
    // edges later; until then the controller is busy and not ready.
    int               m_cnt = 0;
    logic [WIDTH:0]   m_pend = '0;
    logic [WIDTH-1:0] m_sum = '0;
    logic             m_cout = 1'b0;
    logic             m_done = 1'b0;
    logic             m_valid = 1'b0;

    always @(posedge clk) begin
        logic acc_now;
        logic msub;
`ifdef ADD_SEQ_SUB_EN
        msub = sub_i;
`else
        msub = 1'b0;
`endif
        if (!rst_n) begin
            m_cnt = 0; m_sum = '0; m_cout = 1'b0; m_done = 1'b0; m_valid = 1'b1;
        end else begin
            acc_now = start && (m_cnt == 0);
            m_done  = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    {m_cout, m_sum} = m_pend;
                    m_done = 1'b1;
                end
            end
            if (acc_now) begin
                if (msub) m_pend = {1'b0, A} + {1'b0, ~B} + 17'd1;
                else      m_pend = {1'b0, A} + {1'b0, B} + {16'd0, Cin};
                m_cnt = NIB;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_ready", {31'd0, ready}, {31'd0, m_cnt == 0});
            chk("model_busy",  {31'd0, busy},  {31'd0, m_cnt > 0});
            chk("model_done",  {31'd0, done},  {31'd0, m_done});
            chk("model_sum",   {16'd0, Sum},   {16'd0, m_sum});
            chk("model_cout",  {31'd0, Cout},  {31'd0, m_cout});
        end
    end

    // ---------------- directed stimulus ----------------
    // Issues one op; counts edges from acceptance to done and busy cycles.
    // nowait: start is driven in the current negedge slot (back-to-back).
    // glitch: pulse start with A=0x1111 mid-RUN.
    task automatic do_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic s, input logic nowait, input logic glitch,
                         input logic [15:0] es, input logic ec);
        int n, nb;
        if (!nowait) @(negedge clk);
        A = a; B = b; Cin = cin; sub_i = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; nb = busy ? 1 : 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (glitch && n == 1) begin A = 16'h1111; B = 16'h1111; start = 1'b1; end
            if (glitch && n == 2) start = 1'b0;
        end
        chk({nm, "_latency"}, n, NIB);
        chk({nm, "_busycyc"}, nb, NIB);
        chk({nm, "_sum"}, {16'd0, Sum}, {16'd0, es});
        chk({nm, "_cout"}, {31'd0, Cout}, {31'd0, ec});
    endtask

    initial begin
        // reset for 2 edges
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_sum", {16'd0, Sum}, 32'd0);
        chk("rst_cout", {31'd0, Cout}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        rst_n = 1'b1;

        do_op("add4_5", 16'h0004, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 16'h000A, 1'b0);
        do_op("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);

        // back-to-back: second start driven in the first op's DONE cycle
        do_op("b2b_1", 16'h0009, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 16'h000F, 1'b0);
        do_op("b2b_2", 16'h0009, 16'h0009, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0013, 1'b0);

        // reset mid-op at the 2nd RUN edge
        @(negedge clk);
        A = 16'h8888; B = 16'h8888; Cin = 1'b0; start = 1'b1;
        @(negedge clk);             // after acceptance edge
        start = 1'b0;
        @(negedge clk);             // after 1st RUN edge
        rst_n = 1'b0;
        @(negedge clk);             // after 2nd RUN edge (reset)
        rst_n = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (done) seen++;
            end
            chk("midrst_nodone", seen, 0);
        end
        chk("midrst_sum", {16'd0, Sum}, 32'd0);
        chk("midrst_cout", {31'd0, Cout}, 32'd0);
        do_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0);

`ifdef ADD_SEQ_SUB_EN
        do_op("sub_10_1", 16'h0010, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 16'h000F, 1'b1);
        do_op("sub_10_1c", 16'h0010, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h000F, 1'b1);
        do_op("sub_1_2", 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0);
        do_op("sub_1_2c", 16'h0001, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0);
        do_op("sub0_add", 16'h0010, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0012, 1'b0);
`endif
        do_op("mixed", 16'h1234, 16'hEDCB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        do_op("mixed2", 16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
